// File: rtl/sblk_pkg.sv
// sblk_pkg: instruction field widths, packed instruction layout, feed FSM states and decoder
package sblk_pkg;
    localparam int WID_INST_TN = 4;
    localparam int WID_INST_TM = 9;
    localparam int WID_INST_TP = 5;
    localparam int WID_INST_LN = 5;
    localparam int WID_INST_LP = 5;
    localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP + WID_INST_LN + WID_INST_LP;

    typedef struct packed {
        logic [WID_INST_LP-1:0] lp;
        logic [WID_INST_LN-1:0] ln;
        logic [WID_INST_TP-1:0] tp;
        logic [WID_INST_TM-1:0] tm;
        logic [WID_INST_TN-1:0] tn;
    } inst_t;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} fsm_t;

    function automatic inst_t inst_dec(input logic [WID_INST-1:0] d);
        return inst_t'(d);
    endfunction
endpackage

// File: rtl/act_feed_ctrl.sv
// act_feed_ctrl: streams activation batches from the global act buffer to one sub-block on request.
// Optional read-grant stalling is enabled with the ACT_FEED_GNT_EN macro.
module act_feed_ctrl
    import sblk_pkg::*;
#(
    parameter int N_TILE    = 4,
    parameter int WID_ACT   = 8,
    parameter int WID_GADDR = 12
) (
    input  logic                  clk_l,
    input  logic                  rst,
    input  logic [WID_INST-1:0]   inst_data,
    input  logic                  inst_en,
    input  logic                  act_in_req,
    output logic                  act_in_vld,
    output logic [2*WID_ACT-1:0]  act_in,
    output logic                  gbuf_rd_en,
    output logic [WID_GADDR-1:0]  gbuf_rd_addr,
    input  logic [2*WID_ACT-1:0]  gbuf_rd_data,
`ifdef ACT_FEED_GNT_EN
    input  logic                  gbuf_gnt,
`endif
    output logic                  status_feed,
    output logic                  req_ovf
);
    localparam int NB_W   = WID_INST_TN + WID_INST_TP + $clog2(N_TILE + 1);
    localparam int NBAT_W = WID_INST_LN + WID_INST_LP;

    inst_t               inst_q;
    logic                inst_en_d_q;
    logic [NB_W-1:0]     n_beat_q, beat_q;
    logic [NBAT_W-1:0]   n_batch_q, batch_q, req_cnt_q;
    logic [WID_GADDR-1:0] addr_q;
    logic                pend_q, ovf_q, status_q, vld_q;
    fsm_t                state_q, state_d;
    logic                gnt, abort, empty, fire, last, final_b, handoff, room, acc, drop;
    logic                unused_tm;

`ifdef ACT_FEED_GNT_EN
    assign gnt = gbuf_gnt;
`else
    assign gnt = 1'b1;
`endif

    assign unused_tm = ^inst_q.tm;
    assign abort     = inst_en | inst_en_d_q;
    assign empty     = (n_beat_q == '0) | (n_batch_q == '0);
    assign fire      = (state_q == STREAM) & gnt;
    assign last      = beat_q == n_beat_q - NB_W'(1);
    assign final_b   = batch_q == n_batch_q - NBAT_W'(1);
    assign handoff   = fire & last & ~final_b;
    // One waiting batch fits while streaming; the slot frees on the last beat of a non-final batch
    assign room      = (state_q == IDLE) | ((state_q == STREAM) & (~pend_q | handoff));
    assign acc       = act_in_req & ~abort & status_q & ~empty & (req_cnt_q < n_batch_q) & room;
    assign drop      = act_in_req & ~abort & ~acc;

    // FSM state register
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; any instruction load parks the FSM in IDLE
    always_comb begin
        state_d = abort                ? IDLE :
                  (state_q == IDLE)    ? ((pend_q | acc) ? STREAM : IDLE) :
                  (state_q == DRAIN)   ? IDLE :
                  (fire & last)        ? (final_b ? DRAIN : (pend_q | acc) ? STREAM : IDLE) :
                                         STREAM;
    end

    // FSM outputs: one read per granted streaming cycle
    always_comb begin
        gbuf_rd_en = fire;
    end

    // Instruction latch and derived beat/batch totals, widened to avoid truncation
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            inst_q      <= '0;
            inst_en_d_q <= 1'b0;
            n_beat_q    <= '0;
            n_batch_q   <= '0;
        end else begin
            inst_en_d_q <= inst_en;
            if (inst_en) inst_q <= inst_dec(inst_data);
            if (inst_en_d_q) begin
                n_beat_q  <= NB_W'(inst_q.tn) * NB_W'(inst_q.tp) * NB_W'(N_TILE);
                n_batch_q <= NBAT_W'(inst_q.ln) * NBAT_W'(inst_q.lp);
            end
        end
    end

    // Address/beat/batch counters, pending request, overflow flag and status
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            beat_q    <= '0;
            batch_q   <= '0;
            req_cnt_q <= '0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
            status_q  <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            vld_q <= fire & ~inst_en;
            if (abort) begin
                addr_q    <= '0;
                beat_q    <= '0;
                batch_q   <= '0;
                req_cnt_q <= '0;
                pend_q    <= 1'b0;
                ovf_q     <= 1'b0;
                status_q  <= inst_en_d_q | status_q;
            end else begin
                if (fire) begin
                    addr_q  <= addr_q + WID_GADDR'(1);
                    beat_q  <= last ? '0 : beat_q + NB_W'(1);
                    batch_q <= last ? batch_q + NBAT_W'(1) : batch_q;
                end
                if (acc) req_cnt_q <= req_cnt_q + NBAT_W'(1);
                pend_q <= handoff ? (pend_q & acc) : ((state_q == STREAM) & acc) | pend_q;
                if (drop) ovf_q <= 1'b1;
                if ((state_q == DRAIN) | ((state_q == IDLE) & empty)) status_q <= 1'b0;
            end
        end
    end

    assign act_in_vld   = vld_q;
    assign act_in       = vld_q ? gbuf_rd_data : '0;
    assign gbuf_rd_addr = addr_q;
    assign status_feed  = status_q;
    assign req_ovf      = ovf_q;
endmodule
